// File: rtl/image_ram_streamer_pkg.sv
// ---------------------------------------------------------------------------
// image_ram_streamer_pkg
// Constants shared by the image generator / streamer pair. The frame
// geometry, pixel width and RAM address width are the defaults for the
// streamer parameters. The stream FSM state type is also defined here.
// ---------------------------------------------------------------------------
package image_ram_streamer_pkg;

  localparam int unsigned IMAGE_WIDTH             = 320;
  localparam int unsigned IMAGE_HEIGHT            = 240;
  localparam int unsigned PIXEL_WIDTH             = 8;
  localparam int unsigned IMAGE_RAM_ADDRESS_WIDTH = 17;
  localparam int unsigned RAM_READ_LATENCY        = 1;

  // Mid-scale pixel level used by the generator side as its zero point.
  localparam logic [7:0]  DC_OFFSET               = 8'd128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } stream_state_e;

  // Width of a counter that indexes 0..n-1. The result is never below 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_ram_streamer_fifo.sv
// ---------------------------------------------------------------------------
// pixel_stream_fifo
// Small circular FIFO that sits between the RAM read port and the pixel
// stream. Push and pop may happen in the same cycle. A pop on an empty FIFO
// is ignored. A push into a full FIFO is dropped unless a pop happens in the
// same cycle. Storage is cleared on reset, so the output data reads 0.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push         write i_push_data this cycle
//   i_push_data    data to store
//   i_pop          consume the head entry this cycle
//   o_pop_data     head entry (registered storage)
//   o_count        number of stored entries
//   o_empty        high when o_count == 0
// ---------------------------------------------------------------------------
module pixel_stream_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_push_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count != COUNT_FULL) | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/image_ram_streamer.sv
// ---------------------------------------------------------------------------
// image_ram_streamer
// After a start pulse, reads one complete frame from image RAM in raster
// order. Each pixel is presented on a valid/ready stream. The reads are
// credit-limited, so every returning RAM word has a FIFO slot. Because of
// that, backpressure from the sink never drops or repeats a pixel.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               one-cycle pulse: a frame is complete in RAM (only
//                       accepted in IDLE)
//   image_RAM_address   read address (0 whenever CE is low)
//   image_RAM_CE        read enable
//   image_RAM_WE        write enable, always 0
//   image_RAM_q         read data, valid RAM_READ_LATENCY cycles after CE
//   pixel_data/valid    output stream, transfer = valid & ready
//   pixel_ready         sink ready
//   pixel_eol           last pixel of a line (qualifies pixel_data)
//   pixel_last          last pixel of the frame (qualifies pixel_data)
//   busy                high while this block owns the RAM port
//   frame_done          one-cycle pulse after the final transfer
// ---------------------------------------------------------------------------
module image_ram_streamer #(
  parameter int unsigned IMAGE_WIDTH             = image_ram_streamer_pkg::IMAGE_WIDTH,
  parameter int unsigned IMAGE_HEIGHT            = image_ram_streamer_pkg::IMAGE_HEIGHT,
  parameter int unsigned PIXEL_WIDTH             = image_ram_streamer_pkg::PIXEL_WIDTH,
  parameter int unsigned IMAGE_RAM_ADDRESS_WIDTH = image_ram_streamer_pkg::IMAGE_RAM_ADDRESS_WIDTH,
  parameter int unsigned RAM_READ_LATENCY        = image_ram_streamer_pkg::RAM_READ_LATENCY
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] image_RAM_address,
  output logic                               image_RAM_CE,
  output logic                               image_RAM_WE,
  input  logic [PIXEL_WIDTH-1:0]             image_RAM_q,
  output logic [PIXEL_WIDTH-1:0]             pixel_data,
  output logic                               pixel_valid,
  input  logic                               pixel_ready,
  output logic                               pixel_eol,
  output logic                               pixel_last,
  output logic                               busy,
  output logic                               frame_done
);

  import image_ram_streamer_pkg::*;

  localparam int unsigned FIFO_DEPTH   = RAM_READ_LATENCY + 1;
  localparam int unsigned CW           = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRW          = CW + 1;
  localparam int unsigned AW           = IMAGE_RAM_ADDRESS_WIDTH;
  localparam int unsigned TOTAL_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned COL_W        = idx_width(IMAGE_WIDTH);
  localparam int unsigned LINE_W       = idx_width(IMAGE_HEIGHT);

  localparam logic [AW-1:0]     ADDR_LAST  = AW'(TOTAL_PIXELS - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(IMAGE_HEIGHT - 1);
  localparam logic [CRW-1:0]    CREDIT_MAX = CRW'(FIFO_DEPTH);

  stream_state_e               r_state;
  logic [AW-1:0]               r_rd_addr;
  logic [RAM_READ_LATENCY-1:0] r_ce_pipe;
  logic [COL_W-1:0]            r_col;
  logic [LINE_W-1:0]           r_line;
  logic                        r_frame_done;

  logic [CW-1:0]               w_fifo_count;
  logic                        w_fifo_empty;
  logic [PIXEL_WIDTH-1:0]      w_fifo_data;
  logic [CW-1:0]               w_in_flight;
  logic [CRW-1:0]              w_credit_used;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_ce;
  logic                        w_valid;
  logic                        w_eol;
  logic                        w_last;

  // Each bit of the pipe is one issued read still travelling through the
  // RAM. The oldest bit marks the cycle in which image_RAM_q holds that read.
  assign w_push = r_ce_pipe[RAM_READ_LATENCY-1];

  always_comb begin
    w_in_flight = '0;
    for (int unsigned i = 0; i < RAM_READ_LATENCY; i++) begin
      w_in_flight = w_in_flight + CW'(r_ce_pipe[i]);
    end
  end

  // The credit check also counts the entry that is being popped in this
  // cycle as free. Without that, the stream runs at only one pixel every
  // other cycle. The FIFO still cannot overflow, because the popped entry
  // leaves at the same edge.
  assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, w_in_flight}
                       - {{CW{1'b0}}, w_pop};
  assign w_ce = (r_state == ST_STREAM) && (w_credit_used < CREDIT_MAX);

  assign w_valid = ~w_fifo_empty;
  assign w_pop   = w_valid & pixel_ready;
  assign w_eol   = w_valid & (r_col == COL_LAST);
  assign w_last  = w_eol & (r_line == LINE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ce_pipe <= '0;
    end else begin
      r_ce_pipe[0] <= w_ce;
      for (int unsigned i = 1; i < RAM_READ_LATENCY; i++) begin
        r_ce_pipe[i] <= r_ce_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_rd_addr    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_STREAM;
            r_rd_addr <= '0;
          end
        end
        ST_STREAM: begin
          if (w_ce) begin
            r_rd_addr <= r_rd_addr + 1'b1;
            if (r_rd_addr == ADDR_LAST) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_last) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The raster position follows transfers, not reads. It therefore stays
  // aligned with pixel_data even while the sink stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (w_pop) begin
      if (r_col == COL_LAST) begin
        r_col  <= '0;
        r_line <= (r_line == LINE_LAST) ? '0 : r_line + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  pixel_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIXEL_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (w_push),
    .i_push_data (image_RAM_q),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_count     (w_fifo_count),
    .o_empty     (w_fifo_empty)
  );

  assign image_RAM_CE      = w_ce;
  assign image_RAM_address = w_ce ? r_rd_addr : '0;
  assign image_RAM_WE      = 1'b0;
  assign pixel_data        = w_fifo_data;
  assign pixel_valid       = w_valid;
  assign pixel_eol         = w_eol;
  assign pixel_last        = w_last;
  assign busy              = (r_state != ST_IDLE);
  assign frame_done        = r_frame_done;

endmodule

// File: tb/tb_image_ram_streamer.sv
module tb_image_ram_streamer;

  localparam int unsigned W    = 16;
  localparam int unsigned H    = 8;
  localparam int unsigned AW   = 7;
  localparam int           NPIX = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel   = 1'b0;

  logic [AW-1:0] a_addr, b_addr;
  logic          a_ce, a_we, b_ce, b_we;
  logic [7:0]    a_q = '0, b_q = '0, b_s1 = '0;
  logic [7:0]    a_data, b_data;
  logic          a_valid, a_eol, a_last, a_busy, a_done;
  logic          b_valid, b_eol, b_last, b_busy, b_done;

  image_ram_streamer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(8),
    .IMAGE_RAM_ADDRESS_WIDTH(AW), .RAM_READ_LATENCY(1)
  ) u_a (
    .clk(clk), .rst(rst), .start(start),
    .image_RAM_address(a_addr), .image_RAM_CE(a_ce), .image_RAM_WE(a_we),
    .image_RAM_q(a_q), .pixel_data(a_data), .pixel_valid(a_valid),
    .pixel_ready(ready), .pixel_eol(a_eol), .pixel_last(a_last),
    .busy(a_busy), .frame_done(a_done)
  );

  image_ram_streamer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_WIDTH(8),
    .IMAGE_RAM_ADDRESS_WIDTH(AW), .RAM_READ_LATENCY(2)
  ) u_b (
    .clk(clk), .rst(rst), .start(start),
    .image_RAM_address(b_addr), .image_RAM_CE(b_ce), .image_RAM_WE(b_we),
    .image_RAM_q(b_q), .pixel_data(b_data), .pixel_valid(b_valid),
    .pixel_ready(ready), .pixel_eol(b_eol), .pixel_last(b_last),
    .busy(b_busy), .frame_done(b_done)
  );

  // RAM models: mem[a] = a[7:0], with 1-cycle and 2-cycle read latency.
  always @(posedge clk) begin
    if (a_ce) a_q <= {1'b0, a_addr};
    if (b_ce) b_s1 <= {1'b0, b_addr};
    b_q <= b_s1;
  end

  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  logic          m_ce, m_we, m_valid, m_eol, m_last, m_busy, m_done;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_ce    = sel ? b_ce    : a_ce;
  assign m_we    = sel ? b_we    : a_we;
  assign m_data  = sel ? b_data  : a_data;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_eol   = sel ? b_eol   : a_eol;
  assign m_last  = sel ? b_last  : a_last;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;

  int n_vec = 0;
  int n_err = 0;
  int overflow_cnt = 0;

  // A push that arrives while the FIFO is full and nothing is popped means the credit logic failed.
  always @(posedge clk) begin
    if (rst && u_a.r_ce_pipe[0] && u_a.w_fifo_count == 2'd2 && !u_a.w_pop) overflow_cnt++;
    if (rst && u_b.r_ce_pipe[1] && u_b.w_fifo_count == 2'd3 && !u_b.w_pop) overflow_cnt++;
  end

  // mode 0: ready=1; 1: random ~33%; 2: ready low for cycles 1..50.
  // restart_at: re-pulse start after that many transfers; abort_at: stop after that many transfers.
  task automatic run_frame(input int fv_exp, input int depth, input int mode,
                           input int restart_at, input int abort_at, input string tag);
    int   idx = 0, i = 0, first_v = -1, done_cyc = -1, ce_cnt = 0;
    bit   fin = 0, restarted = 0;
    logic p_valid = 0, p_ready = 0, p_eol = 0, p_last = 0;
    logic [7:0] p_data = '0;
    logic [7:0] exp_d;
    start = 1'b1;
    ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(2) == 0) : 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(2) == 0) : 1'b0;
    while (!fin && i < 3000) begin
      i++;
      @(negedge clk);
      if (i == 1) begin
        n_vec++;
        if (m_ce !== 1'b1 || m_addr !== '0)
          begin n_err++; $display("FAIL %s first_read: ce=%b addr=%0d expected ce=1 addr=0", tag, m_ce, m_addr); end
      end
      n_vec++;
      if (m_we !== 1'b0) begin n_err++; $display("FAIL %s we: got %b expected 0", tag, m_we); end
      if (first_v < 0 && m_valid === 1'b1) begin
        first_v = i; n_vec++;
        if (i != fv_exp) begin n_err++; $display("FAIL %s first_valid_cycle: got %0d expected %0d", tag, i, fv_exp); end
      end
      if (mode == 2 && i <= 50) begin
        if (m_ce === 1'b1) ce_cnt++;
        if (i == 50) begin
          n_vec++;
          if (ce_cnt != depth || m_ce !== 1'b0)
            begin n_err++; $display("FAIL %s stall_ce: ce_pulses=%0d ce=%b expected %0d and 0", tag, ce_cnt, m_ce, depth); end
        end
      end
      if (p_valid && !p_ready) begin
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== p_data || m_eol !== p_eol || m_last !== p_last)
          begin n_err++; $display("FAIL %s stall_hold: v=%b d=%0d eol=%b last=%b expected 1 %0d %b %b", tag, m_valid, m_data, m_eol, m_last, p_data, p_eol, p_last); end
      end
      if (done_cyc < 0 || i <= done_cyc) begin
        n_vec++;
        if (m_busy !== 1'b1) begin n_err++; $display("FAIL %s busy: got %b expected 1 at cycle %0d", tag, m_busy, i); end
      end
      if (m_done === 1'b1 && (done_cyc < 0 || i != done_cyc + 1)) begin
        n_vec++; n_err++; $display("FAIL %s early_done: got frame_done=1 at cycle %0d expected 0", tag, i);
      end
      if (m_valid === 1'b1 && ready === 1'b1 && done_cyc < 0) begin
        exp_d = idx[7:0];
        n_vec++;
        if (m_data !== exp_d || m_eol !== (idx % 16 == 15) || m_last !== (idx == NPIX - 1))
          begin n_err++; $display("FAIL %s pixel[%0d]: d=%0d eol=%b last=%b expected d=%0d eol=%b last=%b", tag, idx, m_data, m_eol, m_last, exp_d, (idx % 16 == 15), (idx == NPIX - 1)); end
        if (mode == 0) begin
          n_vec++;
          if (i != fv_exp + idx) begin n_err++; $display("FAIL %s full_rate: pixel %0d at cycle %0d expected %0d", tag, idx, i, fv_exp + idx); end
        end
        idx++;
        if (idx == NPIX) done_cyc = i;
      end
      if (done_cyc > 0 && i == done_cyc + 1) begin
        n_vec++;
        if (m_done !== 1'b1 || m_busy !== 1'b0)
          begin n_err++; $display("FAIL %s frame_done: done=%b busy=%b expected 1 0", tag, m_done, m_busy); end
      end
      if (done_cyc > 0 && i == done_cyc + 2) begin
        n_vec++;
        if (m_done !== 1'b0) begin n_err++; $display("FAIL %s done_pulse: got %b expected 0", tag, m_done); end
        fin = 1;
      end
      p_valid = m_valid; p_ready = ready; p_data = m_data; p_eol = m_eol; p_last = m_last;
      if (abort_at > 0 && idx == abort_at) fin = 1;
      if (!fin) begin
        @(posedge clk); #1;
        ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(2) == 0) : (i + 1 > 50);
        start = 1'b0;
        if (restart_at > 0 && idx == restart_at && !restarted) begin start = 1'b1; restarted = 1; end
      end
    end
    if (!fin) begin n_vec++; n_err++; $display("FAIL %s timeout: %0d transfers expected %0d", tag, idx, NPIX); end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    n_vec++;
    if ({a_valid, a_eol, a_last, a_busy, a_done, a_ce, a_we} !== 7'b0 || a_addr !== '0 || a_data !== 8'd0)
      begin n_err++; $display("FAIL reset_outputs: v%b e%b l%b b%b d%b ce%b we%b a%0d q%0d expected all 0", a_valid, a_eol, a_last, a_busy, a_done, a_ce, a_we, a_addr, a_data); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (a_busy !== 1'b0 || a_ce !== 1'b0)
      begin n_err++; $display("FAIL idle_no_start: busy=%b ce=%b expected 0 0", a_busy, a_ce); end
  endtask

  task automatic test_full_rate;
    run_frame(3, 2, 0, 0, 0, "full_rate");
  endtask

  task automatic test_random_ready;
    run_frame(3, 2, 1, 0, 0, "random_ready");
  endtask

  task automatic test_stall;
    run_frame(3, 2, 2, 0, 0, "stall50");
  endtask

  task automatic test_back_to_back;
    run_frame(3, 2, 0, 20, 0, "restart_ignored");
    run_frame(3, 2, 0, 0, 0, "next_frame");
  endtask

  task automatic test_async_reset;
    run_frame(3, 2, 0, 0, 40, "pre_reset");
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if ({a_valid, a_eol, a_last, a_busy, a_done, a_ce} !== 6'b0 || a_addr !== '0 || a_data !== 8'd0)
      begin n_err++; $display("FAIL async_reset: v%b e%b l%b b%b d%b ce%b a%0d q%0d expected all 0", a_valid, a_eol, a_last, a_busy, a_done, a_ce, a_addr, a_data); end
    @(posedge clk); #1 rst = 1'b1;
    run_frame(3, 2, 0, 0, 0, "after_reset");
  endtask

  task automatic test_latency2;
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    sel = 1'b1;
    run_frame(4, 3, 0, 0, 0, "latency2");
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_full_rate;
    test_random_ready;
    test_stall;
    test_back_to_back;
    test_async_reset;
    test_latency2;
    n_vec++;
    if (overflow_cnt != 0) begin n_err++; $display("FAIL fifo_overflow: got %0d events expected 0", overflow_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
